instr_fetch_unit: RTL and testbench

//   Program counter and fetch FSM feeding the 8-bit CPU decode stage from the ROM.

---
 rtl/instr_fetch_unit_if.sv | 49 ++++
 rtl/instr_fetch_unit.sv | 120 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Purpose: bundles the ROM port, decode handshake and redirect/stall controls of the fetch unit.
// Latency: none (wires only).
// Backpressure: decode applies backpressure through ir_ready; execute redirects via jump_en/jump_addr.
// Ports (master = fetch unit side):
//   rom_addr/rom_data         ROM address out, combinational read data in
//   jump_en/jump_addr/stall   redirect and fetch-inhibit controls in
//   ir_valid/ir_ready         instruction handshake to decode
//   ir_opcode/ir_operand/ir_pc assembled instruction to decode
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              stall;
    logic              ir_valid;
    logic              ir_ready;
    logic [DATA_W-1:0] ir_opcode;
    logic [DATA_W-1:0] ir_operand;
    logic [ADDR_W-1:0] ir_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        input  jump_en,
        input  jump_addr,
        input  stall,
        output ir_valid,
        input  ir_ready,
        output ir_opcode,
        output ir_operand,
        output ir_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        output jump_en,
        output jump_addr,
        output stall,
        input  ir_valid,
        output ir_ready,
        input  ir_opcode,
        input  ir_operand,
        input  ir_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: PC + fetch FSM assembling 1/2-byte instructions from a combinational ROM for decode.
// Latency: 1-byte instr valid 1 cycle after fetch starts, 2-byte after 2; 1 bubble after a jump.
// Backpressure: instruction held stable while ir_ready=0; next opcode fetched in the accept cycle.
// Ports: clk, rst (sync, active-high), bus (instr_fetch_unit_if.master).
// Optional: define IFU_STATS_EN to add output fetch_count[15:0], a saturating count of
//   accepted instructions, cleared only by rst.
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_fetch_unit_if.master   bus
`ifdef IFU_STATS_EN
    ,
    output logic [15:0]          fetch_count
`endif
);

    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_ARG = 2'd1,
        HOLD      = 2'd2
    } state_t;

    state_t            state_q, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic              valid_q, valid_n;
    logic [DATA_W-1:0] opcode_q, opcode_n;
    logic [DATA_W-1:0] operand_q, operand_n;
    logic [ADDR_W-1:0] irpc_q, irpc_n;

    logic              accept;
    logic              two_byte;

    assign bus.rom_addr   = pc_q;
    assign bus.ir_valid   = valid_q;
    assign bus.ir_opcode  = opcode_q;
    assign bus.ir_operand = operand_q;
    assign bus.ir_pc      = irpc_q;

    assign accept   = valid_q & bus.ir_ready;
    assign two_byte = bus.rom_data[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH_OP;
            pc_q      <= RESET_PC;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            operand_q <= '0;
            irpc_q    <= '0;
        end else begin
            state_q   <= state_n;
            pc_q      <= pc_n;
            valid_q   <= valid_n;
            opcode_q  <= opcode_n;
            operand_q <= operand_n;
            irpc_q    <= irpc_n;
        end
    end

    always_comb begin
        state_n   = state_q;
        pc_n      = pc_q;
        valid_n   = valid_q;
        opcode_n  = opcode_q;
        operand_n = operand_q;
        irpc_n    = irpc_q;

        // An opcode fetch starts either from idle or in the cycle the held
        // instruction is accepted, so back-to-back 1-byte instrs run at 1/cycle.
        if ((state_q == FETCH_OP && !bus.stall) ||
            (state_q == HOLD && bus.ir_ready && !bus.stall)) begin
            opcode_n = bus.rom_data;
            irpc_n   = pc_q;
            pc_n     = pc_q + ADDR_W'(1);
            if (two_byte) begin
                valid_n = 1'b0;
                state_n = FETCH_ARG;
            end else begin
                operand_n = '0;
                valid_n   = 1'b1;
                state_n   = HOLD;
            end
        end else if (state_q == FETCH_ARG) begin
            // stall is deliberately ignored: a started instruction completes.
            operand_n = bus.rom_data;
            pc_n      = pc_q + ADDR_W'(1);
            valid_n   = 1'b1;
            state_n   = HOLD;
        end else if (state_q == HOLD && bus.ir_ready) begin
            valid_n = 1'b0;
            state_n = FETCH_OP;
        end

        // Redirect overrides everything; a same-cycle handshake still counts
        // as accepted but the fetch-on-accept above is discarded.
        if (bus.jump_en) begin
            pc_n    = bus.jump_addr;
            valid_n = 1'b0;
            state_n = FETCH_OP;
        end
    end

`ifdef IFU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= '0;
        end else if (accept && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Purpose: directed scoreboard bench for instr_fetch_unit (define IFU_STATS_EN to check fetch_count).
// Latency: expectations queued at stimulus time, popped on each ir_valid&ir_ready.
// Backpressure: bench drives ir_ready directly to exercise hold and accept paths.
module tb_instr_fetch_unit;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] arg;
        logic [7:0] pc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] rom [0:255];
    exp_t exp_q[$];
    exp_t mon_e;
    int tests = 0;
    int fails = 0;

    instr_fetch_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

`ifdef IFU_STATS_EN
    logic [15:0] fetch_count;
    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .bus(bus), .fetch_count(fetch_count));
`else
    instr_fetch_unit #(.ADDR_W(8), .DATA_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    assign bus.rom_data = rom[bus.rom_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic push(input logic [7:0] op, input logic [7:0] arg, input logic [7:0] pc);
        exp_t e;
        e.op = op; e.arg = arg; e.pc = pc;
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        bus.ir_ready  = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = 8'h00;
        bus.stall     = 1'b0;
        tick();
        tick();
        check("rst_valid",   32'(bus.ir_valid),   32'h0);
        check("rst_opcode",  32'(bus.ir_opcode),  32'h0);
        check("rst_operand", 32'(bus.ir_operand), 32'h0);
        check("rst_pc",      32'(bus.ir_pc),      32'h0);
        check("rst_romaddr", 32'(bus.rom_addr),   32'h0);
    endtask

    // Scoreboard monitor: every accepted instruction must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && bus.ir_valid && bus.ir_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr: got op %0h pc %0h, expected none",
                         bus.ir_opcode, bus.ir_pc);
            end else begin
                mon_e = exp_q.pop_front();
                check("mon_opcode",  32'(bus.ir_opcode),  32'(mon_e.op));
                check("mon_operand", 32'(bus.ir_operand), 32'(mon_e.arg));
                check("mon_pc",      32'(bus.ir_pc),      32'(mon_e.pc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.ir_ready  = 1'b0;
        bus.jump_en   = 1'b0;
        bus.jump_addr = 8'h00;
        bus.stall     = 1'b0;

        // 1-byte stream at one instruction per cycle
        clear_rom();
        rom[8'h00] = 8'h01; rom[8'h01] = 8'h02; rom[8'h02] = 8'h03;
        do_reset();
        push(8'h01, 8'h00, 8'h00);
        push(8'h02, 8'h00, 8'h01);
        push(8'h03, 8'h00, 8'h02);
        rst = 1'b0;
        bus.ir_ready = 1'b1;
        tick();
        check("t1_valid_c1",  32'(bus.ir_valid),  32'h1);
        check("t1_opcode_c1", 32'(bus.ir_opcode), 32'h01);
        tick(); tick(); tick();
        bus.ir_ready = 1'b0;

        // 2-byte instruction, held 5 cycles, then resumed
        clear_rom();
        rom[8'h00] = 8'h85; rom[8'h01] = 8'h3C; rom[8'h02] = 8'h04; rom[8'h03] = 8'h05;
        do_reset();
        rst = 1'b0;
        tick();
        check("t2_valid_c1", 32'(bus.ir_valid), 32'h0);
        tick();
        check("t2_valid_c2",   32'(bus.ir_valid),   32'h1);
        check("t2_opcode",     32'(bus.ir_opcode),  32'h85);
        check("t2_operand",    32'(bus.ir_operand), 32'h3C);
        check("t2_irpc",       32'(bus.ir_pc),      32'h00);
        check("t2_pc",         32'(bus.rom_addr),   32'h02);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_hold", {7'b0, bus.ir_valid, bus.ir_opcode, bus.ir_operand, bus.rom_addr},
                  {7'b0, 1'b1, 8'h85, 8'h3C, 8'h02});
        end
        push(8'h85, 8'h3C, 8'h00);
        push(8'h04, 8'h00, 8'h02);
        push(8'h05, 8'h00, 8'h03);
        bus.ir_ready = 1'b1;
        tick(); tick(); tick();
        bus.ir_ready = 1'b0;
`ifdef IFU_STATS_EN
        check("t3_count", 32'(fetch_count), 32'd3);
`endif

        // jump during FETCH_ARG, then jump coinciding with an accept
        clear_rom();
        rom[8'h00] = 8'h85; rom[8'h01] = 8'h3C; rom[8'h40] = 8'h07;
        do_reset();
        rst = 1'b0;
        tick();
        bus.jump_en = 1'b1; bus.jump_addr = 8'h40;
        tick();
        bus.jump_en = 1'b0;
        check("t4_flush_valid", 32'(bus.ir_valid), 32'h0);
        check("t4_jump_pc",     32'(bus.rom_addr), 32'h40);
        tick();
        check("t4_valid", 32'(bus.ir_valid), 32'h1);
        check("t4_irpc",  32'(bus.ir_pc),    32'h40);
        push(8'h07, 8'h00, 8'h40);
        bus.ir_ready = 1'b1;
        bus.jump_en = 1'b1; bus.jump_addr = 8'h00;
        tick();
        bus.jump_en = 1'b0;
        bus.ir_ready = 1'b0;
        check("t4_jacc_valid", 32'(bus.ir_valid), 32'h0);
        check("t4_jacc_pc",    32'(bus.rom_addr), 32'h00);
`ifdef IFU_STATS_EN
        check("t4_count", 32'(fetch_count), 32'd1);
`endif

        // PC wrap across a 2-byte instruction at FF
        clear_rom();
        rom[8'hFF] = 8'h81; rom[8'h00] = 8'hAA; rom[8'h01] = 8'h09;
        do_reset();
        rst = 1'b0;
        bus.jump_en = 1'b1; bus.jump_addr = 8'hFF;
        tick();
        bus.jump_en = 1'b0;
        check("t5_pc_ff", 32'(bus.rom_addr), 32'hFF);
        tick();
        check("t5_pc_wrap", 32'(bus.rom_addr), 32'h00);
        check("t5_valid0",  32'(bus.ir_valid), 32'h0);
        tick();
        check("t5_valid1",   32'(bus.ir_valid), 32'h1);
        check("t5_next_pc",  32'(bus.rom_addr), 32'h01);
        push(8'h81, 8'hAA, 8'hFF);
        bus.ir_ready = 1'b1;
        tick();
        bus.ir_ready = 1'b0;

        // stall in FETCH_OP, then accept under stall
        clear_rom();
        rom[8'h00] = 8'h01;
        do_reset();
        rst = 1'b0;
        bus.stall = 1'b1;
        bus.ir_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_stall_valid", 32'(bus.ir_valid), 32'h0);
            check("t6_stall_pc",    32'(bus.rom_addr), 32'h00);
        end
        bus.stall = 1'b0;
        tick();
        check("t6_valid", 32'(bus.ir_valid), 32'h1);
        push(8'h01, 8'h00, 8'h00);
        bus.stall = 1'b1;
        tick();
        check("t6_acc_stall_valid", 32'(bus.ir_valid), 32'h0);
        check("t6_acc_stall_pc",    32'(bus.rom_addr), 32'h01);
        bus.stall = 1'b0;
        bus.ir_ready = 1'b0;

        // reset in the middle of FETCH_ARG
        clear_rom();
        rom[8'h00] = 8'h85; rom[8'h01] = 8'h3C;
        do_reset();
        rst = 1'b0;
        tick();
        check("t7_pre_opcode", 32'(bus.ir_opcode), 32'h85);
        rst = 1'b1;
        tick();
        check("t7_pc",      32'(bus.rom_addr),   32'h00);
        check("t7_valid",   32'(bus.ir_valid),   32'h0);
        check("t7_opcode",  32'(bus.ir_opcode),  32'h00);
        check("t7_operand", 32'(bus.ir_operand), 32'h00);
        check("t7_irpc",    32'(bus.ir_pc),      32'h00);
`ifdef IFU_STATS_EN
        check("t7_count", 32'(fetch_count), 32'd0);
`endif
        rst = 1'b0;
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
